// File: rtl/vector_adder.sv
// -----------------------------------------------------------------------------
// vector_adder
//
// Joins two independent operand streams (A and B), each behind a one-entry
// buffer, and produces a registered lane-wise sum or difference with per-lane
// carry/borrow flags on a valid/ready output stream.
//
// Parameters
//   ADDER_BITS : width of each lane in bits (>= 2)
//   LANES      : number of independent lanes packed in each data bus (>= 1)
//
// Ports
//   clock    in   single clock, all logic on posedge
//   reset    in   synchronous, active-low reset
//   a_valid  in   A operand valid
//   a_ready  out  A operand accepted when a_valid && a_ready
//   a_data   in   A operand, lane i = bits [i*ADDER_BITS +: ADDER_BITS]
//   b_valid  in   B operand valid
//   b_ready  out  B operand accepted when b_valid && b_ready
//   b_data   in   B operand, same packing as a_data
//   b_sub    in   qualified by b_valid; 1 = A-B, 0 = A+B
//   c_valid  out  result valid
//   c_ready  in   sink ready; result consumed when c_valid && c_ready
//   c_data   out  lane-wise result, same packing
//   c_carry  out  per lane carry-out (add) or borrow (sub, a < b unsigned)
//
// Build option
//   ADDER_SAT_EN : when defined, lanes saturate (add with carry -> all-ones,
//                  sub with borrow -> zero). c_carry still reports the raw
//                  carry/borrow. Handshake and latency are identical in both
//                  builds; the default build (macro undefined) wraps around.
// -----------------------------------------------------------------------------
module vector_adder #(
    parameter int ADDER_BITS = 8,
    parameter int LANES      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [LANES*ADDER_BITS-1:0]   a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [LANES*ADDER_BITS-1:0]   b_data,
    input  logic                          b_sub,
    output logic                          c_valid,
    input  logic                          c_ready,
    output logic [LANES*ADDER_BITS-1:0]   c_data,
    output logic [LANES-1:0]              c_carry
);

    localparam int BUS_W = LANES * ADDER_BITS;

    // One lane of arithmetic on zero-extended operands. The extra top bit is
    // the carry for an add; for a subtract it is the sign of the exact
    // difference, i.e. set exactly when a < b (the borrow).
    function automatic logic [ADDER_BITS:0] lane_arith(
        input logic [ADDER_BITS-1:0] a,
        input logic [ADDER_BITS-1:0] b,
        input logic                  sub
    );
        logic [ADDER_BITS:0] ext_a;
        logic [ADDER_BITS:0] ext_b;
        ext_a = {1'b0, a};
        ext_b = {1'b0, b};
        return sub ? (ext_a - ext_b) : (ext_a + ext_b);
    endfunction

`ifdef ADDER_SAT_EN
    // Clamp an overflowed lane: adds pin to all-ones, subtracts pin to zero.
    function automatic logic [ADDER_BITS-1:0] lane_saturate(
        input logic [ADDER_BITS-1:0] raw,
        input logic                  flag,
        input logic                  sub
    );
        if (!flag) begin
            return raw;
        end
        return sub ? '0 : '1;
    endfunction
`endif

    // Operand buffers
    logic              a_full_q, a_full_d;
    logic [BUS_W-1:0]  a_data_q, a_data_d;
    logic              b_full_q, b_full_d;
    logic [BUS_W-1:0]  b_data_q, b_data_d;
    logic              b_sub_q,  b_sub_d;

    // Output register
    logic              c_valid_q, c_valid_d;
    logic [BUS_W-1:0]  c_data_q,  c_data_d;
    logic [LANES-1:0]  c_carry_q, c_carry_d;

    // Combinational result of the buffered pair
    logic [BUS_W-1:0]  result_data;
    logic [LANES-1:0]  result_carry;

    logic              fire;
    logic              a_hs;
    logic              b_hs;

    always_comb begin
        logic [ADDER_BITS:0] lane_res;
        lane_res     = '0;
        result_data  = '0;
        result_carry = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res = lane_arith(a_data_q[i*ADDER_BITS +: ADDER_BITS],
                                  b_data_q[i*ADDER_BITS +: ADDER_BITS],
                                  b_sub_q);
            result_carry[i] = lane_res[ADDER_BITS];
`ifdef ADDER_SAT_EN
            result_data[i*ADDER_BITS +: ADDER_BITS] =
                lane_saturate(lane_res[ADDER_BITS-1:0], lane_res[ADDER_BITS], b_sub_q);
`else
            result_data[i*ADDER_BITS +: ADDER_BITS] = lane_res[ADDER_BITS-1:0];
`endif
        end
    end

    // Handshake and next-state logic. A buffer can take a new operand in the
    // same cycle it hands its current one to the output register, so ready
    // depends combinationally on c_ready through fire.
    always_comb begin
        fire    = a_full_q && b_full_q && (!c_valid_q || c_ready);
        a_ready = !a_full_q || fire;
        b_ready = !b_full_q || fire;
        a_hs    = a_valid && a_ready;
        b_hs    = b_valid && b_ready;

        a_full_d  = a_full_q;
        a_data_d  = a_data_q;
        b_full_d  = b_full_q;
        b_data_d  = b_data_q;
        b_sub_d   = b_sub_q;
        c_valid_d = c_valid_q;
        c_data_d  = c_data_q;
        c_carry_d = c_carry_q;

        if (fire) begin
            a_full_d = 1'b0;
            b_full_d = 1'b0;
        end
        // A same-cycle capture overrides the clear from fire.
        if (a_hs) begin
            a_full_d = 1'b1;
            a_data_d = a_data;
        end
        if (b_hs) begin
            b_full_d = 1'b1;
            b_data_d = b_data;
            b_sub_d  = b_sub;
        end

        if (fire) begin
            c_valid_d = 1'b1;
            c_data_d  = result_data;
            c_carry_d = result_carry;
        end else if (c_valid_q && c_ready) begin
            c_valid_d = 1'b0;
        end
    end

    // Register stage: operand buffers and output register
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_full_q  <= 1'b0;
            a_data_q  <= '0;
            b_full_q  <= 1'b0;
            b_data_q  <= '0;
            b_sub_q   <= 1'b0;
            c_valid_q <= 1'b0;
            c_data_q  <= '0;
            c_carry_q <= '0;
        end else begin
            a_full_q  <= a_full_d;
            a_data_q  <= a_data_d;
            b_full_q  <= b_full_d;
            b_data_q  <= b_data_d;
            b_sub_q   <= b_sub_d;
            c_valid_q <= c_valid_d;
            c_data_q  <= c_data_d;
            c_carry_q <= c_carry_d;
        end
    end

    assign c_valid = c_valid_q;
    assign c_data  = c_data_q;
    assign c_carry = c_carry_q;

endmodule

// File: tb/tb_vector_adder.sv
// -----------------------------------------------------------------------------
// tb_vector_adder
//
// Self-checking bench for vector_adder (ADDER_BITS=8, LANES=4). A monitor
// records every accepted operand, pairs the k-th A with the k-th B, computes
// the expected lane results with plain integer arithmetic and compares each
// delivered result in order. Directed sequences cover reset, basic add/sub,
// skewed arrival, backpressure, streaming and reset mid-stream, followed by
// a randomized phase. Honours ADDER_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_vector_adder;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int DW = W * L;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [DW-1:0] b_data = '0;
    logic          b_sub = 1'b0;
    logic          c_valid;
    logic          c_ready = 1'b1;
    logic [DW-1:0] c_data;
    logic [L-1:0]  c_carry;

    vector_adder #(.ADDER_BITS(W), .LANES(L)) dut (
        .clock   (clock),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .b_sub   (b_sub),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_data  (c_data),
        .c_carry (c_carry)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference lane arithmetic from the arithmetic rules, using integers.
    function automatic void ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic sub,
                                   output logic [DW-1:0] r, output logic [L-1:0] c);
        int unsigned modv;
        modv = 1 << W;
        r = '0;
        c = '0;
        for (int i = 0; i < L; i++) begin
            int unsigned av;
            int unsigned bv;
            int unsigned res;
            bit          cy;
            av = a[i*W +: W];
            bv = b[i*W +: W];
            if (sub) begin
                cy  = (av < bv);
                res = (av + modv - bv) % modv;
            end else begin
                res = av + bv;
                cy  = (res >= modv);
                res = res % modv;
            end
`ifdef ADDER_SAT_EN
            if (cy) res = sub ? 0 : modv - 1;
`endif
            r[i*W +: W] = res[W-1:0];
            c[i]        = cy;
        end
    endfunction

    // Scoreboard state
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic          qs[$];
    logic [DW-1:0] exp_d[$];
    logic [L-1:0]  exp_c[$];

    // Monitor: samples on the falling edge, when inputs driven after the
    // rising edge and the combinational readies have settled.
    initial begin
        logic          held;
        logic [DW-1:0] held_d;
        logic [L-1:0]  held_c;
        logic [DW-1:0] r;
        logic [L-1:0]  c;
        held = 1'b0;
        held_d = '0;
        held_c = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                qa.delete(); qb.delete(); qs.delete();
                exp_d.delete(); exp_c.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 64'(c_valid), 64'd1);
                    check("hold_data",  64'(c_data),  64'(held_d));
                    check("hold_carry", 64'(c_carry), 64'(held_c));
                end
                if (c_valid && c_ready) begin
                    if (exp_d.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        check("result_data",  64'(c_data),  64'(exp_d[0]));
                        check("result_carry", 64'(c_carry), 64'(exp_c[0]));
                        void'(exp_d.pop_front());
                        void'(exp_c.pop_front());
                        n_out++;
                    end
                end
                held   = c_valid && !c_ready;
                held_d = c_data;
                held_c = c_carry;
                if (a_valid && a_ready) qa.push_back(a_data);
                if (b_valid && b_ready) begin
                    qb.push_back(b_data);
                    qs.push_back(b_sub);
                end
                while (qa.size() > 0 && qb.size() > 0) begin
                    ref_op(qa.pop_front(), qb.pop_front(), qs.pop_front(), r, c);
                    exp_d.push_back(r);
                    exp_c.push_back(c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_bus();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*W +: W] = '0;
                1:       v[i*W +: W] = '1;
                default: v[i*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
        a_valid = 1'b1; a_data = a;
        b_valid = 1'b1; b_data = b; b_sub = sub;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [DW-1:0] er;
        logic [L-1:0]  ec;
        int            out0;
        int            first_cyc;
        int            last_cyc;
        int            vcount;
        logic          a_took;
        logic          b_took;

        // Reset held for two edges with both operand sides valid
        reset = 1'b0;
        a_valid = 1'b1; a_data = rand_bus();
        b_valid = 1'b1; b_data = rand_bus();
        step();
        step();
        check("reset_c_valid", 64'(c_valid), 64'd0);
        check("reset_c_data",  64'(c_data),  64'd0);
        check("reset_c_carry", 64'(c_carry), 64'd0);
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("reset_a_ready", 64'(a_ready), 64'd1);
        check("reset_b_ready", 64'(b_ready), 64'd1);
        step();

        // Basic add: result appears after the second edge
        send_pair(32'h010203FF, 32'h01010101, 1'b0);
        check("add_latency_early", 64'(c_valid), 64'd0);
        step();
        check("add_c_valid", 64'(c_valid), 64'd1);
`ifdef ADDER_SAT_EN
        check("add_c_data", 64'(c_data), 64'h020304FF);
`else
        check("add_c_data", 64'(c_data), 64'h02030400);
`endif
        check("add_c_carry", 64'(c_carry), 64'b0001);
        step();

        // Subtract with borrows in lanes 0 and 2
        send_pair(32'h10000505, 32'h01010506, 1'b1);
        step();
        check("sub_c_valid", 64'(c_valid), 64'd1);
`ifdef ADDER_SAT_EN
        check("sub_c_data", 64'(c_data), 64'h0F000000);
`else
        check("sub_c_data", 64'(c_data), 64'h0FFF00FF);
`endif
        check("sub_c_carry", 64'(c_carry), 64'b0101);
        step();
        step();

        // Skewed arrival: A in cycle 0, B in cycle 5, result in cycle 7
        ra = rand_bus();
        rb = rand_bus();
        a_valid = 1'b1; a_data = ra;
        step();
        a_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("skew_a_ready_c%0d", k), 64'(a_ready), 64'd0);
            if (k == 5) begin
                b_valid = 1'b1; b_data = rb; b_sub = 1'b0;
            end
            step();
        end
        b_valid = 1'b0;
        check("skew_c_valid_c6", 64'(c_valid), 64'd0);
        check("skew_a_ready_c6", 64'(a_ready), 64'd1);
        step();
        check("skew_c_valid_c7", 64'(c_valid), 64'd1);
        ref_op(ra, rb, 1'b0, er, ec);
        check("skew_c_data", 64'(c_data), 64'(er));
        step();
        step();

        // Backpressure: three pairs offered while the sink stalls
        out0 = n_out;
        c_ready = 1'b0;
        send_pair(rand_bus(), rand_bus(), 1'($urandom));
        send_pair(rand_bus(), rand_bus(), 1'($urandom));
        a_valid = 1'b1; a_data = rand_bus();
        b_valid = 1'b1; b_data = rand_bus(); b_sub = 1'($urandom);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("bp_a_ready", 64'(a_ready), 64'd0);
            check("bp_b_ready", 64'(b_ready), 64'd0);
            check("bp_c_valid", 64'(c_valid), 64'd1);
            step();
        end
        c_ready = 1'b1;
        #1;
        check("bp_release_a_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("bp_delivered", 64'(n_out - out0), 64'd3);

        // Streaming: 16 back-to-back pairs with the sink always ready
        out0 = n_out;
        first_cyc = -1;
        last_cyc = -1;
        vcount = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc < 16) begin
                a_valid = 1'b1; a_data = rand_bus();
                b_valid = 1'b1; b_data = rand_bus(); b_sub = 1'($urandom);
                #1;
                check("stream_a_ready", 64'(a_ready), 64'd1);
            end else begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            if (c_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                vcount++;
            end
            step();
        end
        check("stream_count", 64'(vcount), 64'd16);
        check("stream_contiguous", 64'(last_cyc - first_cyc + 1), 64'd16);
        check("stream_delivered", 64'(n_out - out0), 64'd16);

        // Reset mid-stream: output drops and buffered operands are lost
        for (int cyc = 0; cyc < 5; cyc++) begin
            a_valid = 1'b1; a_data = rand_bus();
            b_valid = 1'b1; b_data = rand_bus(); b_sub = 1'($urandom);
            step();
        end
        reset = 1'b0;
        step();
        check("midreset_c_valid", 64'(c_valid), 64'd0);
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("midreset_stays_idle", 64'(c_valid), 64'd0);
        end

        // Randomized traffic with random sink stalls; valid held until taken
        a_took = 1'b0;
        b_took = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_valid || a_took) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data  = rand_bus();
            end
            if (!b_valid || b_took) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data  = rand_bus();
                b_sub   = 1'($urandom);
            end
            c_ready = ($urandom_range(0, 3) != 0);
            #1;
            a_took = a_valid && a_ready;
            b_took = b_valid && b_ready;
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        c_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("drain_pending", 64'(exp_d.size()), 64'd0);
        check("random_outputs_seen", 64'(n_out > 30), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_adder.md
Name: vector_adder

Overview:
Multi-lane successor to the single registered adder. It joins two independent operand streams (A and B), each with a valid/ready handshake, and buffers one operand per side. Once both sides hold data, it produces a registered lane-wise sum or difference with per-lane carry/borrow flags on a valid/ready output stream. It sits between a host-side operand loader and a result sink in the accelerator datapath.

Parameters:
ADDER_BITS, 8, width of each lane in bits (>=2)
LANES, 4, number of independent lanes packed in each data bus (>=1)

Ports:
clock  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-low reset
a_valid  input  1  A operand valid
a_ready  output  1  A operand accepted when a_valid && a_ready
a_data  input  LANES*ADDER_BITS  A operand; lane i = bits [i*ADDER_BITS +: ADDER_BITS]
b_valid  input  1  B operand valid
b_ready  output  1  B operand accepted when b_valid && b_ready
b_data  input  LANES*ADDER_BITS  B operand, same packing as a_data
b_sub  input  1  qualified by b_valid; 1 = compute A-B, 0 = A+B
c_valid  output  1  result valid
c_ready  input  1  sink ready; result consumed when c_valid && c_ready
c_data  output  LANES*ADDER_BITS  lane-wise result, same packing
c_carry  output  LANES  per lane: carry-out (add) or borrow (sub, set when a<b unsigned)

Behaviour:
- Reset (reset==0 at posedge): a_full=b_full=c_valid=0, c_data=0, c_carry=0, operand regs=0, stored sub bit=0. Pending operands and undelivered results are discarded, including mid-transfer.
- Operand buffers: one entry each. On an A handshake, capture a_data and set a_full. On a B handshake, capture b_data and b_sub, and set b_full.
- fire = a_full && b_full && (!c_valid || c_ready).
- a_ready = !a_full || fire; b_ready = !b_full || fire. The combinational path from c_ready to a_ready/b_ready is intentional.
- On fire: c_data/c_carry load from the buffered operands, c_valid<=1. a_full/b_full clear unless a new handshake on that side happens in the same cycle, in which case the new operand is captured and the flag stays 1.
- Not firing but c_valid && c_ready: c_valid<=0.
- c_data and c_carry hold stable while c_valid && !c_ready.
- Latency: operands accepted at edge t -> c_valid high after edge t+1 (if the output is free). Steady-state throughput: 1 result per cycle with both inputs streaming and c_ready=1.
- A and B may arrive in different cycles. A lone operand is held indefinitely, and that side's ready stays low until the other side arrives and fire occurs.
- Arithmetic: unsigned, per lane, no cross-lane carry. Add: {carry, sum} = a+b (ADDER_BITS+1 bits), c_data = low ADDER_BITS (wraps modulo 2^ADDER_BITS). Sub: c_data = (a-b) mod 2^ADDER_BITS, carry = borrow.

Optional Feature:
ADDER_SAT_EN
- Defined: saturating lanes. An add with carry clamps c_data lane to all-ones. A sub with borrow clamps c_data lane to 0. c_carry is still reported as without saturation.
- Undefined: wrap-around arithmetic as above. Handshake and latency are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with a_valid=b_valid=1 -> c_valid=0, c_data=0, c_carry=0. a_ready=b_ready=1 after release.
- Basic add, LANES=4, ADDER_BITS=8: a=0x01_02_03_FF, b=0x01_01_01_01, b_sub=0, same cycle -> two edges later c_data=0x02_03_04_00, c_carry=4'b0001. In an ADDER_SAT_EN build, lane0 is 0xFF.
- Subtract: a=0x10_00_05_05, b=0x01_01_05_06, b_sub=1 -> c_data=0x0F_FF_00_FF, c_carry=4'b0101. In an ADDER_SAT_EN build, lanes 0 and 2 are 0x00.
- Skewed arrival: A at cycle 0, B at cycle 5 -> a_ready=0 in cycles 1-5, c_valid first high at cycle 7. Sum is correct.
- Backpressure: c_ready=0 with 3 operand pairs offered -> one result held stable, one pair buffered, a_ready=b_ready=0. Release c_ready -> results delivered in order, none dropped or duplicated.
- Streaming: 16 back-to-back pairs with c_ready=1 -> 16 results on consecutive cycles. Then assert reset mid-stream -> c_valid=0 next cycle, buffered operands discarded.
